// File: rtl/tdm_demux_pkg.sv
// -----------------------------------------------------------------------------
// tdm_demux_pkg
//   Shared definitions for the 1-to-4 TDM demultiplexer: channel count,
//   select width, select codes and the select-to-one-hot decode helper.
//   Optional feature macro used by the top level: TDM_DEMUX_STATS_EN.
// -----------------------------------------------------------------------------
package tdm_demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [SEL_W-1:0] {
        CH0 = 2'b00,
        CH1 = 2'b01,
        CH2 = 2'b10,
        CH3 = 2'b11
    } chan_sel_e;

    // Decode a channel select code into a one-hot channel vector.
    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        case (sel)
            CH0:     oh = 4'b0001;
            CH1:     oh = 4'b0010;
            CH2:     oh = 4'b0100;
            CH3:     oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/tdm_demux_chan.sv
// -----------------------------------------------------------------------------
// tdm_demux_chan
//   One-entry output buffer with a valid/ready handshake towards a consumer.
//   A fill loads the word and sets valid; a drain (valid & ready) without a
//   fill clears valid while the data register keeps its last value.
//   Fill and drain in the same cycle keep valid high with the new word.
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   fill_i       in   load data_i into the buffer this cycle
//   data_i       in   WIDTH word to load
//   ready_i      in   consumer takes the buffered word this cycle
//   valid_o      out  buffer holds a valid word (registered)
//   data_o       out  buffered word (registered)
//   can_accept_o out  buffer is empty or is being drained this cycle
// -----------------------------------------------------------------------------
module tdm_demux_chan #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             can_accept_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state for the buffer: fill wins over drain so a same-cycle
    // drain and refill produces no bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (fill_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign can_accept_o = ~valid_q | ready_i;

endmodule

// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
//   1-to-4 demultiplexer for a time-multiplexed bus. The word on in_data is
//   routed to the channel selected by {s1,s0} and held in that channel's
//   one-entry buffer until its consumer takes it. in_ready is combinational
//   and reflects only the currently selected channel, so upstream may change
//   the select while stalled.
//   Optional feature: define TDM_DEMUX_STATS_EN to add saturating
//   per-channel accepted-word counters cnt0..cnt3 (parameter CNT_W).
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_data/in_valid  muxed input word and its valid
//   in_ready          word accepted this cycle when in_valid is also high
//   s1, s0            channel select: 00->ch0 .. 11->ch3
//   out0..out3        channel buffered data
//   v0..v3            channel buffer valid
//   r0..r3            channel consumer ready
//   cnt0..cnt3        channel accepted-word count (stats build only)
// -----------------------------------------------------------------------------
module tdm_demux4
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 1
`ifdef TDM_DEMUX_STATS_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
`ifdef TDM_DEMUX_STATS_EN
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
`endif
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             v0,
    output logic             v1,
    output logic             v2,
    output logic             v3,
    input  logic             r0,
    input  logic             r1,
    input  logic             r2,
    input  logic             r3
);

    logic [SEL_W-1:0]  sel_s;
    logic [NUM_CH-1:0] ready_s;
    logic [NUM_CH-1:0] can_accept_s;
    logic [NUM_CH-1:0] valid_s;
    logic [NUM_CH-1:0] fill_s;
    logic [WIDTH-1:0]  data_s [NUM_CH];
    logic              accept_s;

    assign sel_s    = {s1, s0};
    assign ready_s  = {r3, r2, r1, r0};
    assign in_ready = can_accept_s[sel_s];
    assign accept_s = in_valid & in_ready;

    // Route an accepted word to exactly one channel; nothing is filled
    // while the input is idle or stalled.
    always_comb begin
        fill_s = {NUM_CH{1'b0}};
        if (accept_s) begin
            fill_s = sel_onehot(sel_s);
        end else begin
            fill_s = {NUM_CH{1'b0}};
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        tdm_demux_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .fill_i       (fill_s[k]),
            .data_i       (in_data),
            .ready_i      (ready_s[k]),
            .valid_o      (valid_s[k]),
            .data_o       (data_s[k]),
            .can_accept_o (can_accept_s[k])
        );
    end

    assign out0 = data_s[0];
    assign out1 = data_s[1];
    assign out2 = data_s[2];
    assign out3 = data_s[3];
    assign v0   = valid_s[0];
    assign v1   = valid_s[1];
    assign v2   = valid_s[2];
    assign v3   = valid_s[3];

`ifdef TDM_DEMUX_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];

    // Saturating increment on each accept to the channel; never wraps.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (fill_s[k] && (cnt_q[k] != CNT_MAX)) begin
                cnt_d[k] = cnt_q[k] + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d[k] = cnt_q[k];
            end
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`else
    // No statistics in this build.
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux4
//   Self-checking bench for tdm_demux4 (WIDTH=8). A table of vectors and a
//   few hand-written sequences drive the demux; accepted words are pushed to
//   a scoreboard queue and popped after the following clock edge, while a
//   small reference model tracks every channel's valid flag and data.
// -----------------------------------------------------------------------------
module tb_tdm_demux4;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       s1, s0;
    logic [7:0] out0, out1, out2, out3;
    logic       v0, v1, v2, v3;
    logic       r0, r1, r2, r3;
`ifdef TDM_DEMUX_STATS_EN
    logic [3:0] cnt0, cnt1, cnt2, cnt3;
`endif

    int n_checks = 0;
    int n_err    = 0;

    tdm_demux4 #(
        .WIDTH(8)
`ifdef TDM_DEMUX_STATS_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef TDM_DEMUX_STATS_EN
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .cnt2     (cnt2),
        .cnt3     (cnt3),
`endif
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .s1       (s1),
        .s0       (s0),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .v0       (v0),
        .v1       (v1),
        .v2       (v2),
        .v3       (v3),
        .r0       (r0),
        .r1       (r1),
        .r2       (r2),
        .r3       (r3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] dout [4];
    logic [3:0] dv;
    assign dout[0] = out0;
    assign dout[1] = out1;
    assign dout[2] = out2;
    assign dout[3] = out3;
    assign dv      = {v3, v2, v1, v0};

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
    } sb_t;
    sb_t exp_q[$];

    logic       mdl_v   [4];
    logic [7:0] mdl_out [4];

    typedef struct {
        logic       vld;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] r;
        logic       exp_rdy;
        logic [3:0] exp_v;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mdl_v[k]   = 1'b0;
            mdl_out[k] = 8'h00;
        end
        exp_q.delete();
    endtask

    // One cycle: drive inputs, check in_ready, clock, check scoreboard and model.
    task automatic apply(input logic vld, input logic [1:0] sel, input logic [7:0] d,
                         input logic [3:0] rr, input logic exp_rdy, input string tag);
        logic       nv [4];
        sb_t        e;
        in_valid = vld;
        {s1, s0} = sel;
        in_data  = d;
        {r3, r2, r1, r0} = rr;
        #1;
        check({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
        for (int k = 0; k < 4; k++) begin
            nv[k] = mdl_v[k] & ~rr[k];
        end
        if (vld && exp_rdy) begin
            exp_q.push_back('{sel, d});
            nv[sel]      = 1'b1;
            mdl_out[sel] = d;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            mdl_v[k] = nv[k];
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_sb_data"}, {24'd0, dout[e.ch]}, {24'd0, e.data});
            check({tag, "_sb_valid"}, {31'd0, dv[e.ch]}, 32'd1);
        end
        for (int k = 0; k < 4; k++) begin
            check({tag, "_model_v"}, {31'd0, dv[k]}, {31'd0, mdl_v[k]});
            check({tag, "_model_out"}, {24'd0, dout[k]}, {24'd0, mdl_out[k]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        {s1, s0} = 2'b00;
        {r3, r2, r1, r0} = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_v", {28'd0, dv}, 32'd0);
        for (int k = 0; k < 4; k++) check("reset_out", {24'd0, dout[k]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Routing, full-buffer stall, parallel drains, drain+fill.
        tbl[0] = '{1'b1, 2'd0, 8'hA0, 4'b0000, 1'b1, 4'b0001};
        tbl[1] = '{1'b1, 2'd1, 8'hA1, 4'b0000, 1'b1, 4'b0011};
        tbl[2] = '{1'b1, 2'd2, 8'hA2, 4'b0000, 1'b1, 4'b0111};
        tbl[3] = '{1'b1, 2'd3, 8'hA3, 4'b0000, 1'b1, 4'b1111};
        tbl[4] = '{1'b1, 2'd0, 8'hB0, 4'b0000, 1'b0, 4'b1111};
        tbl[5] = '{1'b0, 2'd0, 8'h00, 4'b0101, 1'b1, 4'b1010};
        tbl[6] = '{1'b1, 2'd1, 8'hC1, 4'b0000, 1'b0, 4'b1010};
        tbl[7] = '{1'b1, 2'd0, 8'hC0, 4'b0000, 1'b1, 4'b1011};
        tbl[8] = '{1'b1, 2'd3, 8'hC3, 4'b1000, 1'b1, 4'b1011};
        tbl[9] = '{1'b0, 2'd2, 8'h00, 4'b1111, 1'b1, 4'b0000};
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].r, tbl[i].exp_rdy, "tbl");
            check("tbl_exp_v", {28'd0, dv}, {28'd0, tbl[i].exp_v});
        end
        check("tbl_out3_after_refill", {24'd0, out3}, 32'hC3);

        // Reset mid-cycle with all four channels full.
        for (int k = 0; k < 4; k++) apply(1'b1, 2'(k), 8'hF0 + 8'(k), 4'b0000, 1'b1, "fill");
        #2;
        rst = 1'b1;
        #1;
        check("midreset_v", {28'd0, dv}, 32'd0);
        for (int k = 0; k < 4; k++) check("midreset_out", {24'd0, dout[k]}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Backpressure on ch2, then drain and refill in the same cycle.
        apply(1'b1, 2'd2, 8'hD0, 4'b0000, 1'b1, "bp_first");
        apply(1'b1, 2'd2, 8'hD1, 4'b0000, 1'b0, "bp_stall");
        apply(1'b1, 2'd2, 8'hD1, 4'b0100, 1'b1, "bp_release");
        check("bp_out2", {24'd0, out2}, 32'hD1);
        check("bp_v2", {31'd0, v2}, 32'd1);
        apply(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, "bp_drain");

        // Stall on ch1, then reselect ch3.
        apply(1'b1, 2'd1, 8'hE1, 4'b0000, 1'b1, "rs_fill1");
        apply(1'b1, 2'd1, 8'hE2, 4'b0000, 1'b0, "rs_stall");
        apply(1'b1, 2'd3, 8'hE2, 4'b0000, 1'b1, "rs_resel");
        check("rs_out3", {24'd0, out3}, 32'hE2);
        check("rs_out1", {24'd0, out1}, 32'hE1);
        apply(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, "rs_drain");

        // Streaming: 100 back-to-back words to ch0.
        for (int i = 0; i < 100; i++) begin
            apply(1'b1, 2'd0, 8'(i) ^ 8'h3C, 4'b0001, 1'b1, "stream");
        end
        apply(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, "stream_drain");
        check("stream_last_out0", {24'd0, out0}, {24'd0, 8'd99 ^ 8'h3C});

`ifdef TDM_DEMUX_STATS_EN
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check("stats_reset_cnt3", {28'd0, cnt3}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 2'd3, 8'(i), 4'b1000, 1'b1, "stats");
            if (i == 4) check("stats_cnt3_5", {28'd0, cnt3}, 32'd5);
        end
        check("stats_cnt3_sat", {28'd0, cnt3}, 32'd15);
        check("stats_cnt0", {28'd0, cnt0}, 32'd0);
        check("stats_cnt1", {28'd0, cnt1}, 32'd0);
        check("stats_cnt2", {28'd0, cnt2}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
